// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard unit for the 5-stage RISC-V pipeline. A per-register countdown
// scoreboard tracks how many cycles remain until each in-flight result can
// be forwarded. This covers ALU, load and multi-cycle MUL/DIV latencies.
// From it the unit derives the Fetch/Decode stalls, the Decode/Execute
// flushes and the Execute forwarding selects. It also keeps a saturating
// count of stalled cycles.
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int REGW   = $clog2(NREG),
    parameter int MAXLAT = 8,
    parameter int CNTW   = $clog2(MAXLAT + 1),
    parameter int PERFW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    // Decode stage
    input  logic             valid_d,
    input  logic [REGW-1:0]  rs1_d,
    input  logic [REGW-1:0]  rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [REGW-1:0]  rd_d,
    input  logic             regwrite_d,
    input  logic [CNTW-1:0]  lat_d,
    // Execute stage
    input  logic [REGW-1:0]  rs1_e,
    input  logic [REGW-1:0]  rs2_e,
    // Memory / Writeback stages
    input  logic [REGW-1:0]  rd_m,
    input  logic             regwrite_m,
    input  logic [REGW-1:0]  rd_w,
    input  logic             regwrite_w,
    // Control redirect
    input  logic             pcsrc_e,
    // Hazard controls
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [PERFW-1:0] stall_cnt
);

    localparam logic [CNTW-1:0] LAT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] LAT_MAX = CNTW'(MAXLAT);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    // Scoreboard: cycles remaining until each register's result is forwardable.
    // Entry 0 is never loaded and so stays at zero.
    logic [CNTW-1:0]  cnt_q [NREG];
    logic [CNTW-1:0]  cnt_d [NREG];

    logic [PERFW-1:0] stall_cnt_q;
    logic [PERFW-1:0] stall_cnt_d;

    logic [CNTW-1:0]  lat_eff;
    logic [CNTW-1:0]  cnt_rs1;
    logic [CNTW-1:0]  cnt_rs2;
    logic [CNTW-1:0]  cnt_rd;

    logic             haz_raw;
    logic             haz_waw;
    logic             hazard;
    logic             issue;
    logic             load_en;

    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    // Clamp the requested latency into [1, MAXLAT]; zero means single-cycle.
    always_comb begin
        lat_eff = lat_d;
        if (lat_d == '0) begin
            lat_eff = LAT_ONE;
        end else if (lat_d > LAT_MAX) begin
            lat_eff = LAT_MAX;
        end
    end

    // Look up the scoreboard entries for the Decode operands and destination.
    always_comb begin
        cnt_rs1 = cnt_q[rs1_d];
        cnt_rs2 = cnt_q[rs2_d];
        cnt_rd  = cnt_q[rd_d];
    end

    // RAW/WAW detection. A taken branch squashes Decode, so it overrides any stall.
    always_comb begin
        haz_raw = valid_d & ((use_rs1_d & (cnt_rs1 > LAT_ONE)) |
                             (use_rs2_d & (cnt_rs2 > LAT_ONE)));
        // A younger write must not complete before an older one to the same rd.
        haz_waw = valid_d & regwrite_d & (rd_d != '0) & (cnt_rd > lat_eff);
        hazard  = (haz_raw | haz_waw) & ~pcsrc_e;
        issue   = valid_d & ~hazard & ~pcsrc_e;
        load_en = issue & regwrite_d & (rd_d != '0);
    end

    // Next scoreboard state: count every busy entry down; an issuing writer
    // reloads its destination, and the reload takes priority over the decrement.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = '0;
            if (r != 0) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - LAT_ONE;
                end
                if (load_en && (rd_d == REGW'(r))) begin
                    cnt_d[r] = lat_eff;
                end
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Stall-cycle counter, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERFW'(1);
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Forwarding selects: Memory stage is younger, so it wins over Writeback.
    always_comb begin
        fwd_a = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs1_e)) begin
            fwd_a = FWD_M;
        end else if (regwrite_w && (rd_w != '0) && (rd_w == rs1_e)) begin
            fwd_a = FWD_W;
        end

        fwd_b = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs2_e)) begin
            fwd_b = FWD_M;
        end else if (regwrite_w && (rd_w != '0) && (rd_w == rs2_e)) begin
            fwd_b = FWD_W;
        end
    end

    // Drive outputs; all are forced low while reset is held, with no clock edge needed.
    always_comb begin
        stall_f   = reset & hazard;
        stall_d   = reset & hazard;
        flush_d   = reset & pcsrc_e;
        flush_e   = reset & (hazard | pcsrc_e);
        fwd_a_e   = reset ? fwd_a : FWD_RF;
        fwd_b_e   = reset ? fwd_b : FWD_RF;
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed pipeline scenarios plus
// randomized traffic checked against a completion-time reference model.
module tb_hazard_scoreboard;

    localparam int NREG   = 32;
    localparam int REGW   = 5;
    localparam int MAXLAT = 8;
    localparam int CNTW   = 4;
    localparam int PERFW  = 5;
    localparam int SAT    = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             valid_d;
    logic [REGW-1:0]  rs1_d, rs2_d, rd_d;
    logic             use_rs1_d, use_rs2_d, regwrite_d;
    logic [CNTW-1:0]  lat_d;
    logic [REGW-1:0]  rs1_e, rs2_e, rd_m, rd_w;
    logic             regwrite_m, regwrite_w, pcsrc_e;
    logic             stall_f, stall_d, flush_d, flush_e;
    logic [1:0]       fwd_a_e, fwd_b_e;
    logic [PERFW-1:0] stall_cnt;

    hazard_scoreboard #(
        .NREG   (NREG),
        .MAXLAT (MAXLAT),
        .PERFW  (PERFW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_d    (valid_d),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .use_rs1_d  (use_rs1_d),
        .use_rs2_d  (use_rs2_d),
        .rd_d       (rd_d),
        .regwrite_d (regwrite_d),
        .lat_d      (lat_d),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_m       (rd_m),
        .regwrite_m (regwrite_m),
        .rd_w       (rd_w),
        .regwrite_w (regwrite_w),
        .pcsrc_e    (pcsrc_e),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .fwd_a_e    (fwd_a_e),
        .fwd_b_e    (fwd_b_e),
        .stall_cnt  (stall_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: for each register, the first cycle number at which
    // its pending result has fully drained (0 = nothing pending).
    int   done_at [NREG];
    int   cyc;
    int   exp_cnt;
    logic exp_hazard, exp_issue;
    logic [7:0] exp_vec;
    logic [7:0] obs_vec;

    assign obs_vec = {stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e};

    function automatic int remaining(input int r);
        if (r == 0) return 0;
        return (done_at[r] > cyc) ? (done_at[r] - cyc) : 0;
    endfunction

    function automatic int leff(input int l);
        if (l == 0) return 1;
        if (l > MAXLAT) return MAXLAT;
        return l;
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [REGW-1:0] src);
        if (regwrite_m && rd_m != 0 && rd_m == src) return 2'b10;
        if (regwrite_w && rd_w != 0 && rd_w == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_eval();
        logic raw, waw;
        raw = valid_d && ((use_rs1_d && remaining(int'(rs1_d)) > 1) ||
                          (use_rs2_d && remaining(int'(rs2_d)) > 1));
        waw = valid_d && regwrite_d && rd_d != 0 &&
              remaining(int'(rd_d)) > leff(int'(lat_d));
        exp_hazard = (raw || waw) && !pcsrc_e;
        exp_issue  = valid_d && !exp_hazard && !pcsrc_e;
        exp_vec = {exp_hazard, exp_hazard, pcsrc_e, (exp_hazard || pcsrc_e),
                   fwd_ref(rs1_e), fwd_ref(rs2_e)};
        if (!reset) exp_vec = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) done_at[i] = 0;
        exp_cnt = 0;
    endtask

    // Advance one clock edge, updating the model with what the edge commits.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (reset) begin
            if (exp_issue && regwrite_d && rd_d != 0)
                done_at[rd_d] = cyc + 1 + leff(int'(lat_d));
            if (exp_hazard && exp_cnt < SAT) exp_cnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        valid_d = 0; rs1_d = 0; rs2_d = 0; use_rs1_d = 0; use_rs2_d = 0;
        rd_d = 0; regwrite_d = 0; lat_d = 0;
        rs1_e = 0; rs2_e = 0; rd_m = 0; regwrite_m = 0; rd_w = 0; regwrite_w = 0;
        pcsrc_e = 0;
    endtask

    task automatic set_dec(input logic v, input int r1, input logic u1,
                           input int r2, input logic u2,
                           input int rd, input logic rw, input int lat);
        valid_d = v; rs1_d = REGW'(r1); use_rs1_d = u1;
        rs2_d = REGW'(r2); use_rs2_d = u2;
        rd_d = REGW'(rd); regwrite_d = rw; lat_d = CNTW'(lat);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 0;
        #1;
        model_clear();
        @(posedge clk);
        cyc++;
        #1;
        reset = 1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 0;
        pcsrc_e = 1; rd_m = 3; regwrite_m = 1; rs1_e = 3;
        rd_w = 4; regwrite_w = 1; rs2_e = 4;
        #1;
        n_checks++;
        if (obs_vec !== 8'h00) $display("FAIL reset_outputs got=%b exp=00000000", obs_vec);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== '0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 5, 1, 1);
        #1;
        n_checks++;
        if (stall_d !== 1'b0) $display("FAIL alu_issue stall_d=%b exp=0", stall_d);
        else n_pass++;
        tick();
        set_dec(1, 5, 1, 0, 0, 11, 1, 1);
        #1;
        n_checks++;
        if ({stall_d, flush_e} !== 2'b00) $display("FAIL alu_dep stall_d/flush_e=%b exp=00", {stall_d, flush_e});
        else n_pass++;
        tick();
        set_idle();
        rd_m = 5; regwrite_m = 1; rs1_e = 5; rd_w = 5; regwrite_w = 1;
        #1;
        n_checks++;
        if ({fwd_a_e, fwd_b_e} !== 4'b1000) $display("FAIL alu_fwd fwd_a/b=%b exp=1000", {fwd_a_e, fwd_b_e});
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 6, 1, 2);
        tick();
        set_dec(1, 6, 1, 0, 0, 12, 1, 1);
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101)
            $display("FAIL load_use_stall sf/sd/fd/fe=%b exp=1101", {stall_f, stall_d, flush_d, flush_e});
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000)
            $display("FAIL load_use_release sf/sd/fd/fe=%b exp=0000", {stall_f, stall_d, flush_d, flush_e});
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 5'd1) $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt);
        else n_pass++;
        tick();
        set_idle();
        rs1_e = 6; rd_w = 6; regwrite_w = 1;
        #1;
        n_checks++;
        if (fwd_a_e !== 2'b01) $display("FAIL load_use_fwd fwd_a=%b exp=01", fwd_a_e);
        else n_pass++;
    endtask

    task automatic test_mul();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 7, 1, 4);
        tick();
        set_dec(1, 0, 0, 7, 1, 13, 1, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (stall_d !== 1'b1) $display("FAIL mul_stall cycle=%0d stall_d=%b exp=1", i, stall_d);
            else n_pass++;
            tick();
        end
        #1;
        n_checks++;
        if (stall_d !== 1'b0) $display("FAIL mul_release stall_d=%b exp=0", stall_d);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 5'd3) $display("FAIL mul_cnt got=%0d exp=3", stall_cnt);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (stall_cnt !== 5'd3) $display("FAIL mul_cnt_hold got=%0d exp=3", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_branch_squash();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 9, 1, 3);
        tick();
        set_dec(1, 9, 1, 0, 0, 10, 1, 3);
        #1;
        n_checks++;
        if (stall_d !== 1'b1) $display("FAIL br_pre_stall stall_d=%b exp=1", stall_d);
        else n_pass++;
        pcsrc_e = 1;
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011)
            $display("FAIL br_squash sf/sd/fd/fe=%b exp=0011", {stall_f, stall_d, flush_d, flush_e});
        else n_pass++;
        tick();
        pcsrc_e = 0;
        set_dec(1, 10, 1, 0, 0, 0, 0, 1);
        #1;
        n_checks++;
        if (stall_d !== 1'b0) $display("FAIL br_rd_clear stall_d=%b exp=0", stall_d);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 5'd0) $display("FAIL br_cnt got=%0d exp=0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_x0_waw();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 0, 1, 4);
        tick();
        set_dec(1, 0, 1, 0, 1, 0, 0, 1);
        rd_m = 0; regwrite_m = 1; rs1_e = 0;
        rd_w = 0; regwrite_w = 1; rs2_e = 0;
        #1;
        n_checks++;
        if ({stall_d, fwd_a_e, fwd_b_e} !== 5'b00000)
            $display("FAIL x0_read stall_d/fwd_a/fwd_b=%b exp=00000", {stall_d, fwd_a_e, fwd_b_e});
        else n_pass++;
        set_idle();
        set_dec(1, 0, 0, 0, 0, 8, 1, 6);
        tick();
        set_dec(1, 0, 0, 0, 0, 8, 1, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (stall_d !== 1'b1) $display("FAIL waw_stall cycle=%0d stall_d=%b exp=1", i, stall_d);
            else n_pass++;
            tick();
        end
        #1;
        n_checks++;
        if (stall_d !== 1'b0) $display("FAIL waw_release stall_d=%b exp=0", stall_d);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 7, 1, 4);
        tick();
        set_dec(1, 7, 1, 0, 0, 14, 1, 1);
        rd_m = 3; regwrite_m = 1; rs1_e = 3;
        #1;
        n_checks++;
        if ({stall_d, fwd_a_e} !== 3'b110) $display("FAIL mm_pre stall_d/fwd_a=%b exp=110", {stall_d, fwd_a_e});
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (stall_cnt !== 5'd1) $display("FAIL mm_cnt_pre got=%0d exp=1", stall_cnt);
        else n_pass++;
        #1;
        reset = 0;
        pcsrc_e = 1;
        #1;
        n_checks++;
        if (obs_vec !== 8'h00) $display("FAIL mm_async_out got=%b exp=00000000", obs_vec);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 5'd0) $display("FAIL mm_async_cnt got=%0d exp=0", stall_cnt);
        else n_pass++;
        model_clear();
        @(posedge clk);
        cyc++;
        #1;
        reset = 1;
        pcsrc_e = 0;
        #1;
        n_checks++;
        if (stall_d !== 1'b0) $display("FAIL mm_after stall_d=%b exp=0", stall_d);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        set_dec(1, 1, 1, 0, 0, 1, 1, 8);
        repeat (16) tick();
        #1;
        n_checks++;
        if (stall_cnt !== 5'd14) $display("FAIL sat_mid got=%0d exp=14", stall_cnt);
        else n_pass++;
        repeat (40) tick();
        #1;
        n_checks++;
        if (stall_cnt !== 5'd31) $display("FAIL sat_hold got=%0d exp=31", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int i = 0; i < 200; i++) begin
                set_dec($urandom_range(0, 99) < 85,
                        $urandom_range(0, 7), $urandom_range(0, 1),
                        $urandom_range(0, 7), $urandom_range(0, 1),
                        $urandom_range(0, 7), $urandom_range(0, 1),
                        $urandom_range(0, 15));
                rs1_e = REGW'($urandom_range(0, 7));
                rs2_e = REGW'($urandom_range(0, 7));
                rd_m = REGW'($urandom_range(0, 7));
                rd_w = REGW'($urandom_range(0, 7));
                regwrite_m = $urandom_range(0, 1);
                regwrite_w = $urandom_range(0, 1);
                pcsrc_e = ($urandom_range(0, 99) < 8);
                #1;
                model_eval();
                n_checks++;
                if (obs_vec !== exp_vec)
                    $display("FAIL rand_out blk=%0d i=%0d got=%b exp=%b", blk, i, obs_vec, exp_vec);
                else n_pass++;
                n_checks++;
                if (stall_cnt !== PERFW'(exp_cnt))
                    $display("FAIL rand_cnt blk=%0d i=%0d got=%0d exp=%0d", blk, i, stall_cnt, exp_cnt);
                else n_pass++;
                tick();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        set_idle();
        reset = 0;
        model_clear();
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_mul();
        test_branch_squash();
        test_x0_waw();
        test_reset_mid_mul();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
